ultrasonic_scheduler: RTL and testbench
=======================================

Name: ultrasonic_scheduler

Overview:
Round-robin controller that drives up to N HC-SR04-style ultrasonic sensors from one shared measurement datapath (one prescaler, one echo timer, one cm counter). It fires one trigger pulse at a time, times that sensor's echo, and converts the echo width to centimetres by counting 58 us intervals, so no divider is needed. It streams results as (sensor index, distance, timeout) records to downstream display and speaker logic, and sits between the board pins and the distance consumers.

Parameters:
N_SENSORS, 2, number of sensors served; range 1..8
CLK_HZ, 100_000_000, clock frequency in Hz
TRIG_US, 10, trigger pulse width in us
CM_US, 58, echo microseconds per centimetre
MAX_CM, 400, saturation distance in cm; must be <= 511
ARM_TIMEOUT_US, 2000, maximum wait from trigger end to echo rise
GAP_US, 60000, dead time after each report before the next trigger

Ports:
clk_100MHz  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level signal; run the scheduler while high
echo_in  in  N_SENSORS  raw asynchronous echo pins
trig_out  out  N_SENSORS  trigger pins; at most one bit is high at any time
dist_cm  out  9  last reported distance
dist_sel  out  SELW  sensor index of the last report; SELW = max(1,$clog2(N_SENSORS))
dist_valid  out  1  one-cycle strobe when a new record is presented
timeout  out  1  qualifies the record: 1 means no echo or a saturated echo
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs are 0; state goes to IDLE; cur_sel=0; synchronizers, counters and prescaler are cleared. Reset takes effect immediately even mid-measurement. trig_out drops in the same instant.
- Echo input: each echo_in bit passes through a 2-FF synchronizer. Edge detection uses the synchronized value and its previous-cycle value.
- us_tick: one-cycle pulse every TICK_DIV=CLK_HZ/1_000_000 cycles. The prescaler restarts on every state entry so that state durations are exact.
- IDLE: if enable=1, go to TRIG.
- TRIG: trig_out[cur_sel]=1 for exactly TRIG_US*TICK_DIV cycles, then go to ARM.
- ARM: wait for a rising edge on sync echo[cur_sel].
  - An echo already high on entry is ignored until it goes low and then rises again.
  - On a rising edge: clear us_cnt and cm_cnt, go to MEAS.
  - After ARM_TIMEOUT_US ticks with no rising edge: result = (MAX_CM, timeout=1), go to REPORT.
- MEAS: us_cnt counts ticks. When us_cnt reaches CM_US-1, us_cnt wraps to 0 and cm_cnt increments.
  - On a falling edge of sync echo[cur_sel]: result = (cm_cnt, timeout=0).
  - If cm_cnt reaches MAX_CM before the fall: result = (MAX_CM, timeout=1), without waiting for the fall.
  - If the fall and the saturation occur in the same cycle, the fall wins and timeout=0.
  - Both exits go to REPORT.
- REPORT: lasts one cycle.
  - dist_cm, dist_sel and timeout are registered and held until the next report.
  - dist_valid=1 for this cycle only.
  - cur_sel advances (N_SENSORS-1 wraps to 0).
  - Next state is GAP.
- GAP: wait GAP_US ticks. Then go to TRIG if enable=1, otherwise go to IDLE.
- enable deasserted mid-cycle: the current measurement completes and is reported; the block stops after GAP. Deasserting enable never truncates a trigger pulse.
- Latency: echo_in falling edge to dist_valid is 3 cycles (2 synchronizer stages + 1).
- Distance rounding: truncation. Echo width w us reports floor(w/58) cm, with +/-1 tick of quantization.
- Echoes on non-selected sensors are ignored.

Optional Feature:
Macro US_SCHED_NEAREST_EN.
- When defined, add outputs nearest_cm (9 bits), nearest_sel (SELW bits) and round_done (1 bit).
- During a round, track the minimum non-timeout distance; on ties the lower index wins.
- When the report for sensor N_SENSORS-1 is presented, present the round minimum and pulse round_done for 1 cycle.
- If every sensor in the round timed out: nearest_cm = MAX_CM and nearest_sel = 0.
- Reset clears all three outputs.
- When the macro is undefined, these ports and their logic do not exist.

Decomposition:
- Package us_sched_pkg holds:
  - the state enum (IDLE, TRIG, ARM, MEAS, REPORT, GAP);
  - TICK_DIV and the counter-width localparams derived by $clog2;
  - DIST_W = 9.
- Sub-module us_tick_gen: the microsecond prescaler, with a synchronous restart input and a tick output.

Test Plan:
- Defaults, N=2, enable=1, echo_in[0] high for 580 us after trigger -> trig_out[0] high for 1000 cycles; dist_valid with dist_cm=10, dist_sel=0, timeout=0.
- No echo on sensor 1 -> report after 2000 us in ARM with dist_cm=400, dist_sel=1, timeout=1; the next trigger goes to sensor 0 after 60000 us.
- Echo held high for 30000 us -> report at 23200 us into MEAS with dist_cm=400, timeout=1; the remainder of the echo is ignored.
- Echo already high at ARM entry, then low, then a rising edge followed by 1160 us high -> dist_cm=20; the stale level is not measured.
- enable dropped mid-MEAS; reset_n pulsed low mid-TRIG in a second run -> the first run reports and then enters IDLE with busy=0; the second run has all outputs 0 immediately and trig_out low.
- With US_SCHED_NEAREST_EN: distances 50 and 30 -> round_done with nearest_cm=30, nearest_sel=1.

Source files
------------

// File: rtl/ultrasonic_scheduler_pkg.sv
// us_sched_pkg: shared FSM state type, widths and derived-constant helpers for the ultrasonic scheduler.
package us_sched_pkg;
   typedef enum logic [2:0] {IDLE, TRIG, ARM, MEAS, REPORT, GAP} state_t;
   localparam int DIST_W = 9;
   function automatic int tick_div(int clk_hz);
      return clk_hz / 1_000_000;
   endfunction
   // bits needed to hold 0..n-1, never less than one
   function automatic int cnt_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int TICK_DIV = tick_div(100_000_000);
endpackage

// File: rtl/ultrasonic_scheduler_if.sv
// ultrasonic_scheduler_if: result record stream from the scheduler to distance consumers.
// Nearest-sensor fields exist only when US_SCHED_NEAREST_EN is defined.
interface ultrasonic_scheduler_if #(parameter int SELW = 1);
   import us_sched_pkg::*;
   logic [DIST_W-1:0] dist_cm;
   logic [SELW-1:0]   dist_sel;
   logic              dist_valid;
   logic              timeout;
`ifdef US_SCHED_NEAREST_EN
   logic [DIST_W-1:0] nearest_cm;
   logic [SELW-1:0]   nearest_sel;
   logic              round_done;
   modport master(output dist_cm, dist_sel, dist_valid, timeout, nearest_cm, nearest_sel, round_done);
   modport slave(input dist_cm, dist_sel, dist_valid, timeout, nearest_cm, nearest_sel, round_done);
`else
   modport master(output dist_cm, dist_sel, dist_valid, timeout);
   modport slave(input dist_cm, dist_sel, dist_valid, timeout);
`endif
endinterface

// File: rtl/ultrasonic_scheduler_tick_gen.sv
// us_tick_gen: microsecond prescaler; restart realigns the tick phase to the current cycle.
module us_tick_gen
   import us_sched_pkg::*;
#(parameter int DIV = TICK_DIV)
(
   input  logic clk_100MHz,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);
   localparam int W = cnt_w(DIV);
   logic [W-1:0] cnt;
   assign tick = cnt == W'(DIV - 1);
   always_ff @(posedge clk_100MHz or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin HC-SR04 trigger/echo timing with one shared datapath.
// Define US_SCHED_NEAREST_EN to add per-round nearest-sensor reporting.
module ultrasonic_scheduler
   import us_sched_pkg::*;
#(
   parameter int N_SENSORS      = 2,
   parameter int CLK_HZ         = 100_000_000,
   parameter int TRIG_US        = 10,
   parameter int CM_US          = 58,
   parameter int MAX_CM         = 400,
   parameter int ARM_TIMEOUT_US = 2000,
   parameter int GAP_US         = 60000
)
(
   input  logic                 clk_100MHz,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] echo_in,
   output logic [N_SENSORS-1:0] trig_out,
   output logic                 busy,
   ultrasonic_scheduler_if.master rpt
);
   localparam int SELW = cnt_w(N_SENSORS);
   localparam int TDIV = tick_div(CLK_HZ);
   localparam int TW   = cnt_w(TRIG_US + ARM_TIMEOUT_US + GAP_US);
   localparam int UW   = cnt_w(CM_US);
   localparam logic [SELW-1:0] LAST_SEL = SELW'(N_SENSORS - 1);
   localparam logic [DIST_W-1:0] MAX_D = DIST_W'(MAX_CM);
   state_t state, state_n;
   logic [N_SENSORS-1:0] echo_s1, echo_s2, echo_d;
   logic [SELW-1:0] cur_sel;
   logic [TW-1:0] tmr;
   logic [UW-1:0] us_cnt;
   logic [DIST_W-1:0] cm_cnt, fin_cm;
   logic tick, restart, rise, fall, fin, fin_to, us_wrap;
   assign rise     = echo_s2[cur_sel] & ~echo_d[cur_sel];
   assign fall     = ~echo_s2[cur_sel] & echo_d[cur_sel];
   assign restart  = state_n != state;
   assign us_wrap  = us_cnt == UW'(CM_US - 1);
   assign trig_out = (state == TRIG) ? N_SENSORS'(1) << cur_sel : '0;
   assign busy     = state != IDLE;
   assign rpt.dist_valid = state == REPORT;
   us_tick_gen #(.DIV(TDIV)) u_tick (
      .clk_100MHz(clk_100MHz),
      .reset_n   (reset_n),
      .restart   (restart),
      .tick      (tick)
   );
   always_comb begin
      state_n = state;
      fin     = 1'b0;
      fin_cm  = MAX_D;
      fin_to  = 1'b1;
      case (state)
         IDLE:   state_n = enable ? TRIG : IDLE;
         TRIG:   state_n = (tick && tmr == TW'(TRIG_US - 1)) ? ARM : TRIG;
         ARM: begin
            if (rise) state_n = MEAS;
            else if (tick && tmr == TW'(ARM_TIMEOUT_US - 1)) begin
               state_n = REPORT;
               fin     = 1'b1;
            end
         end
         // a fall in the saturation cycle still reports the measured width
         MEAS: begin
            if (fall || cm_cnt == MAX_D) begin
               state_n = REPORT;
               fin     = 1'b1;
               fin_cm  = fall ? cm_cnt : MAX_D;
               fin_to  = !fall;
            end
         end
         REPORT: state_n = GAP;
         GAP:    state_n = (tick && tmr == TW'(GAP_US - 1)) ? (enable ? TRIG : IDLE) : GAP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         {echo_d, echo_s2, echo_s1} <= '0;
         tmr <= '0;
      end else begin
         state <= state_n;
         {echo_d, echo_s2, echo_s1} <= {echo_s2, echo_s1, echo_in};
         tmr <= restart ? '0 : tmr + TW'(tick);
      end
   end
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         us_cnt <= '0;
         cm_cnt <= '0;
      end else if (state != MEAS) begin
         us_cnt <= '0;
         cm_cnt <= '0;
      end else if (tick) begin
         us_cnt <= us_wrap ? '0 : us_cnt + 1'b1;
         cm_cnt <= cm_cnt + DIST_W'(us_wrap);
      end
   end
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         cur_sel      <= '0;
         rpt.dist_cm  <= '0;
         rpt.dist_sel <= '0;
         rpt.timeout  <= 1'b0;
      end else begin
         if (fin) begin
            rpt.dist_cm  <= fin_cm;
            rpt.dist_sel <= cur_sel;
            rpt.timeout  <= fin_to;
         end
         if (state == REPORT) cur_sel <= (cur_sel == LAST_SEL) ? '0 : cur_sel + 1'b1;
      end
   end
`ifdef US_SCHED_NEAREST_EN
   logic [DIST_W-1:0] run_cm, near_cm_q, best_cm;
   logic [SELW-1:0] run_sel, near_sel_q, best_sel;
   logic run_any, cand;
   // strict less-than keeps the earlier (lower-index) sensor on ties
   assign cand     = !rpt.timeout && (!run_any || rpt.dist_cm < run_cm);
   assign best_cm  = cand ? rpt.dist_cm : (run_any ? run_cm : MAX_D);
   assign best_sel = cand ? rpt.dist_sel : (run_any ? run_sel : '0);
   assign rpt.round_done  = state == REPORT && rpt.dist_sel == LAST_SEL;
   assign rpt.nearest_cm  = rpt.round_done ? best_cm : near_cm_q;
   assign rpt.nearest_sel = rpt.round_done ? best_sel : near_sel_q;
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         run_any    <= 1'b0;
         run_cm     <= '0;
         run_sel    <= '0;
         near_cm_q  <= '0;
         near_sel_q <= '0;
      end else if (rpt.round_done) begin
         run_any    <= 1'b0;
         near_cm_q  <= best_cm;
         near_sel_q <= best_sel;
      end else if (state == REPORT && cand) begin
         run_any <= 1'b1;
         run_cm  <= rpt.dist_cm;
         run_sel <= rpt.dist_sel;
      end
   end
`endif
endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb_ultrasonic_scheduler: directed checks of trigger width, echo timing, timeouts, enable and reset.
// Time constants are scaled down (2 clocks per us) so every scenario stays short.
module tb_ultrasonic_scheduler;
   import us_sched_pkg::*;
   localparam int DIV = 2, GAP = 300, ARM_TO = 200, TRIG = 10, MAXC = 30;
   logic clk_100MHz = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic [1:0] echo_in = '0;
   logic [1:0] trig_out;
   logic busy;
   int n_chk = 0, n_pass = 0, c, w, extra;
   bit multi = 1'b0;
   ultrasonic_scheduler_if #(.SELW(1)) rpt();
   ultrasonic_scheduler #(
      .N_SENSORS(2), .CLK_HZ(DIV * 1_000_000), .TRIG_US(TRIG), .CM_US(58),
      .MAX_CM(MAXC), .ARM_TIMEOUT_US(ARM_TO), .GAP_US(GAP)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .reset_n   (reset_n),
      .enable    (enable),
      .echo_in   (echo_in),
      .trig_out  (trig_out),
      .busy      (busy),
      .rpt       (rpt)
   );
   always #5 clk_100MHz = ~clk_100MHz;
   always @(negedge clk_100MHz) if (!$onehot0(trig_out)) multi = 1'b1;
   task automatic check(string tag, int got, int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   task automatic wait_trig(int i, output int cyc);
      cyc = 0;
      while (!trig_out[i] && cyc < 5000) begin
         @(negedge clk_100MHz);
         cyc++;
      end
   endtask
   task automatic trig_width(int i, output int n);
      n = 0;
      while (trig_out[i] && n < 5000) begin
         @(negedge clk_100MHz);
         n++;
      end
   endtask
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!rpt.dist_valid && cyc < 20000) begin
         @(negedge clk_100MHz);
         cyc++;
      end
   endtask
   task automatic expect_rec(string tag, int cm, int sel, int to);
      check({tag, "_valid"}, rpt.dist_valid, 1);
      check({tag, "_cm"}, rpt.dist_cm, cm);
      check({tag, "_sel"}, rpt.dist_sel, sel);
      check({tag, "_to"}, rpt.timeout, to);
   endtask
   task automatic pulse_echo(int i, int high);
      echo_in[i] = 1'b1;
      repeat (high) @(negedge clk_100MHz);
      echo_in[i] = 1'b0;
   endtask
`ifdef US_SCHED_NEAREST_EN
   int rd_cm[$], rd_sel[$];
   always @(negedge clk_100MHz) if (rpt.round_done) begin
      rd_cm.push_back(rpt.nearest_cm);
      rd_sel.push_back(rpt.nearest_sel);
   end
`endif
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      repeat (3) @(negedge clk_100MHz);
      check("rst_trig", trig_out, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", rpt.dist_valid, 0);
      check("rst_cm", rpt.dist_cm, 0);
      check("rst_to", rpt.timeout, 0);
      reset_n = 1'b1;
      enable  = 1'b1;
      // sensor 0: 1162 high cycles = 580 ticks -> 10 cm
      wait_trig(0, c);
      check("trig0_seen", trig_out[0], 1);
      trig_width(0, w);
      check("trig0_width", w, TRIG * DIV);
      repeat (4) @(negedge clk_100MHz);
      pulse_echo(0, 1162);
      wait_valid(c);
      check("fall_latency", c, 3);
      expect_rec("m10", 10, 0, 0);
      // sensor 1: no echo -> arm timeout
      wait_trig(1, c);
      check("gap_a", c - 1, GAP * DIV);
      trig_width(1, w);
      check("trig1_width", w, TRIG * DIV);
      wait_valid(c);
      check("arm_wait", c, ARM_TO * DIV);
      expect_rec("noecho", MAXC, 1, 1);
      wait_trig(0, c);
      check("wrap_sel0", trig_out[0], 1);
      check("gap_b", c - 1, GAP * DIV);
      // stale level through trigger and ARM entry, then real 20 cm echo
      echo_in[0] = 1'b1;
      trig_width(0, w);
      repeat (50) @(negedge clk_100MHz);
      echo_in[0] = 1'b0;
      repeat (20) @(negedge clk_100MHz);
      pulse_echo(0, 2322);
      wait_valid(c);
      expect_rec("stale", 20, 0, 0);
      // sensor 1: echo far longer than MAX_CM -> saturated report while echo still high
      wait_trig(1, c);
      trig_width(1, w);
      repeat (4) @(negedge clk_100MHz);
      echo_in[1] = 1'b1;
      wait_valid(c);
      check("sat_latency", c, 3484);
      expect_rec("sat", MAXC, 1, 1);
      extra = 0;
      repeat (500) begin
         @(negedge clk_100MHz);
         if (rpt.dist_valid) extra++;
      end
      echo_in[1] = 1'b0;
      repeat (50) begin
         @(negedge clk_100MHz);
         if (rpt.dist_valid) extra++;
      end
      check("sat_no_extra", extra, 0);
      // enable dropped mid-measurement: report still arrives, then IDLE
      wait_trig(0, c);
      trig_width(0, w);
      repeat (4) @(negedge clk_100MHz);
      echo_in[0] = 1'b1;
      repeat (100) @(negedge clk_100MHz);
      enable = 1'b0;
      repeat (1062) @(negedge clk_100MHz);
      echo_in[0] = 1'b0;
      wait_valid(c);
      check("en_latency", c, 3);
      expect_rec("en_drop", 10, 0, 0);
      repeat (700) @(negedge clk_100MHz);
      check("idle_busy", busy, 0);
      check("idle_trig", trig_out, 0);
      // second run: asynchronous reset in the middle of a trigger
      enable = 1'b1;
      wait_trig(1, c);
      check("run2_trig1", trig_out[1], 1);
      repeat (5) @(negedge clk_100MHz);
      #2 reset_n = 1'b0;
      #1;
      check("arst_trig", trig_out, 0);
      check("arst_busy", busy, 0);
      check("arst_cm", rpt.dist_cm, 0);
      check("arst_valid", rpt.dist_valid, 0);
      check("arst_to", rpt.timeout, 0);
      @(negedge clk_100MHz);
      reset_n = 1'b1;
      wait_trig(0, c);
      check("arst_sel0", trig_out[0], 1);
      check("onehot_trig", multi, 0);
`ifdef US_SCHED_NEAREST_EN
      check("near_rounds", rd_cm.size() >= 2, 1);
      if (rd_cm.size() >= 2) begin
         check("near_r1_cm", rd_cm[0], 10);
         check("near_r1_sel", rd_sel[0], 0);
         check("near_r2_cm", rd_cm[1], 20);
      end
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
